// File: rtl/axil_stats_poller_pkg.sv
// Shared types and constants for the AXI-lite stats poller.
package axil_stats_poller_pkg;

    // AXI-lite response codes; TIMEOUT reuses the DECERR encoding so that a
    // hung slave is reported in-band on the result stream.
    localparam logic [1:0] AXI_RESP_OK       = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
    localparam logic [1:0] AXIL_RESP_TIMEOUT = 2'b11;

    // Auto-advancing registers of the stats/control slave.
    localparam logic [31:0] STATS_ADDR  = 32'h0000_0020;
    localparam logic [31:0] DDR_RD_ADDR = 32'h0000_0060;
    localparam logic [31:0] DDR_WR_ADDR = 32'h0000_0080;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RSP,
        ST_DRAIN
    } poller_state_e;

    // One captured bus result, held stable on the response stream.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rsp_beat_t;

endpackage

// File: rtl/axil_timeout_counter.sv
// Saturating cycle counter that flags when a bus response is overdue.
module axil_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over count; the counter parks at LIMIT instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/axil_stats_poller.sv
// AXI-lite master that drains auto-advancing stats registers one word per
// read, or performs single writes, returning every result on a
// valid/ready stream. A hung slave is timed out and its late response is
// drained so the bus stays protocol-legal.
module axil_stats_poller
    import axil_stats_poller_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    mem_clk,
    input  logic                    mem_aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [CNT_WIDTH-1:0]    cmd_count,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic [CNT_WIDTH-1:0]    rsp_index,
    output logic                    rsp_last,

    output logic                    timeout_sticky,

    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    poller_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]   remain_q, remain_d;
    logic [CNT_WIDTH-1:0]   index_q, index_d;
    rsp_beat_t              rsp_q, rsp_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   bready_q, bready_d;
    logic                   drain_q, drain_d;
    logic                   sticky_q, sticky_d;

    logic                   tmr_clr, tmr_en, tmr_expired;
    logic                   aw_done, w_done, late_hs;

    axil_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmr (
        .clk_i     (mem_clk),
        .rst_ni    (mem_aresetn),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state and registered-output logic; every bus control is a flop
    // so the AXI outputs are glitch-free.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        remain_d  = remain_q;
        index_d   = index_q;
        rsp_d     = rsp_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        drain_d   = drain_q;
        sticky_d  = sticky_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        late_hs   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    remain_d = (cmd_count == '0) ? CNT_WIDTH'(1) : cmd_count;
                    index_d  = '0;
                    drain_d  = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_AWW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end

            ST_AR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    tmr_clr   = 1'b1;
                    state_d   = ST_R;
                end
            end

            // A response on the expiry cycle still counts as a response.
            ST_R: begin
                if (m_axil_rvalid && rready_q) begin
                    rsp_d.data = m_axil_rdata;
                    rsp_d.resp = m_axil_rresp;
                    rsp_d.last = (remain_q == CNT_WIDTH'(1));
                    rready_d   = 1'b0;
                    state_d    = ST_RSP;
                end else if (tmr_expired) begin
                    rsp_d.data = '0;
                    rsp_d.resp = AXIL_RESP_TIMEOUT;
                    rsp_d.last = 1'b1;
                    sticky_d   = 1'b1;
                    drain_d    = 1'b1;
                    state_d    = ST_RSP;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            // Address and data channels complete independently.
            ST_AWW: begin
                aw_done = !awvalid_q || m_axil_awready;
                w_done  = !wvalid_q  || m_axil_wready;
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    tmr_clr  = 1'b1;
                    state_d  = ST_B;
                end
            end

            ST_B: begin
                if (m_axil_bvalid && bready_q) begin
                    rsp_d.data = '0;
                    rsp_d.resp = m_axil_bresp;
                    rsp_d.last = 1'b1;
                    bready_d   = 1'b0;
                    state_d    = ST_RSP;
                end else if (tmr_expired) begin
                    rsp_d.data = '0;
                    rsp_d.resp = AXIL_RESP_TIMEOUT;
                    rsp_d.last = 1'b1;
                    sticky_d   = 1'b1;
                    drain_d    = 1'b1;
                    state_d    = ST_RSP;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            // rready/bready stay high after a timeout, so a late response
            // may already land here; it is consumed and the drain skipped.
            ST_RSP: begin
                late_hs = drain_q && ((rready_q && m_axil_rvalid) ||
                                      (bready_q && m_axil_bvalid));
                if (late_hs) begin
                    drain_d  = 1'b0;
                    rready_d = 1'b0;
                    bready_d = 1'b0;
                end
                if (rsp_ready) begin
                    if (drain_d) begin
                        state_d = ST_DRAIN;
                    end else if (rsp_q.last) begin
                        state_d = ST_IDLE;
                    end else begin
                        remain_d  = remain_q - 1'b1;
                        index_d   = index_q + 1'b1;
                        arvalid_d = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end

            // No timeout here: the slave owes exactly one response.
            ST_DRAIN: begin
                if ((rready_q && m_axil_rvalid) || (bready_q && m_axil_bvalid)) begin
                    rready_d = 1'b0;
                    bready_d = 1'b0;
                    drain_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge mem_clk) begin
        if (!mem_aresetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            remain_q    <= '0;
            index_q     <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            drain_q     <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remain_q    <= remain_d;
            index_q     <= index_d;
            rsp_q       <= rsp_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            drain_q     <= drain_d;
            sticky_q    <= sticky_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = (state_q == ST_RSP);
    assign rsp_data       = rsp_q.data;
    assign rsp_resp       = rsp_q.resp;
    assign rsp_last       = rsp_q.last;
    assign rsp_index      = index_q;
    assign timeout_sticky = sticky_q;

    // The address is deliberately not advanced between reads of a command.
    assign m_axil_araddr  = addr_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;

endmodule

// File: tb/tb_axil_stats_poller.sv
// Bench for axil_stats_poller: table of commands checked through a
// response scoreboard, plus hand sequences for latency, split AW/W
// handshakes, timeout/drain, backpressure and mid-transaction reset.
module tb_axil_stats_poller;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int TMO = 16;

    logic          mem_clk = 1'b0;
    logic          mem_aresetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_last, timeout_sticky;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] rsp_index;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;

    // slave knobs, driven by the main sequence
    logic          ar_rdy = 1'b1, aw_rdy = 1'b1, w_rdy = 1'b1;
    logic          r_hang = 1'b0, r_force = 1'b0;
    logic [1:0]    b_cfg = 2'b00;
    int            rsp_mode = 0;

    // slave state
    logic          s_rvalid = 1'b0, s_bvalid = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [DW-1:0] s_rdata = '0, s_wdata = '0, s_stats = '0;
    logic [1:0]    s_rresp = '0, s_bresp = '0;
    logic [AW-1:0] s_awaddr = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_len_hi = 1'b0;
    int            cyc = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [7:0]  idx;
        logic        last;
    } rsp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  cnt;
        logic [1:0]  bresp;
        int          rmode;
        int          exp_n;
    } vec_t;

    rsp_t        exp_q[$];
    vec_t        vt[8];
    int          n_vec = 0, n_err = 0;
    logic [31:0] m_stats = '0;
    bit          m_len_hi = 1'b0;

    axil_stats_poller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .mem_clk(mem_clk), .mem_aresetn(mem_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_index(rsp_index), .rsp_last(rsp_last),
        .timeout_sticky(timeout_sticky),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(aw_rdy),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(w_rdy), .m_axil_bresp(s_bresp), .m_axil_bvalid(s_bvalid),
        .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
        .m_axil_arready(ar_rdy), .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp),
        .m_axil_rvalid(s_rvalid), .m_axil_rready(rready)
    );

    initial forever #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) cyc <= cyc + 1;

    // Slave read side: one-cycle registered response; 0x20 advances a stats
    // counter, 0x60 returns the 48-bit length low word then high word.
    always @(posedge mem_clk) begin
        if (!mem_aresetn) begin
            s_rvalid <= 1'b0;
        end else begin
            if (s_rvalid && rready) s_rvalid <= 1'b0;
            if (arvalid && ar_rdy && !r_hang) begin
                s_rvalid <= 1'b1;
                s_rresp  <= 2'b00;
                if (araddr == 32'h20) begin
                    s_rdata <= 32'hC0DE_0000 + s_stats;
                    s_stats <= s_stats + 1;
                end else if (araddr == 32'h60) begin
                    s_rdata  <= s_len_hi ? 32'h0000_0001 : 32'h2345_6789;
                    s_len_hi <= !s_len_hi;
                end else begin
                    s_rdata <= {16'hA000, araddr[15:0]};
                    s_rresp <= (araddr == 32'h80) ? 2'b00 : 2'b10;
                end
            end
            if (r_force) begin
                s_rvalid <= 1'b1;
                s_rdata  <= 32'hDEAD_BEEF;
                s_rresp  <= 2'b00;
            end
        end
    end

    // Slave write side: bvalid one cycle after both AW and W have landed.
    always @(posedge mem_clk) begin
        if (!mem_aresetn) begin
            s_bvalid <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
        end else begin
            if (awvalid && aw_rdy) begin
                aw_got   <= 1'b1;
                s_awaddr <= awaddr;
            end
            if (wvalid && w_rdy) begin
                w_got   <= 1'b1;
                s_wdata <= wdata;
                s_wstrb <= wstrb;
            end
            if ((aw_got || (awvalid && aw_rdy)) && (w_got || (wvalid && w_rdy)) && !s_bvalid) begin
                s_bvalid <= 1'b1;
                s_bresp  <= b_cfg;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end else if (s_bvalid && bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rsp_drive();
        forever begin
            @(posedge mem_clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    endtask

    task automatic rsp_monitor();
        rsp_t got, want;
        forever begin
            @(negedge mem_clk);
            if (rsp_valid && rsp_ready) begin
                got = '{rsp_data, rsp_resp, rsp_index, rsp_last};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_rsp: got data=%h resp=%b idx=%0d last=%b, want none",
                             got.data, got.resp, got.idx, got.last);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL rsp[%0d]: got data=%h resp=%b idx=%0d last=%b, want data=%h resp=%b idx=%0d last=%b",
                                 want.idx, got.data, got.resp, got.idx, got.last,
                                 want.data, want.resp, want.idx, want.last);
                    end
                end
            end
        end
    endtask

    // Expected read results, from an independent model of the slave registers.
    task automatic push_read(input logic [31:0] addr, input int n);
        rsp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = 8'(i);
            e.last = (i == n - 1);
            e.resp = 2'b00;
            if (addr == 32'h20) begin
                e.data  = 32'hC0DE_0000 + m_stats;
                m_stats = m_stats + 1;
            end else if (addr == 32'h60) begin
                e.data   = m_len_hi ? 32'h0000_0001 : 32'h2345_6789;
                m_len_hi = !m_len_hi;
            end else begin
                e.data = {16'hA000, addr[15:0]};
                e.resp = (addr == 32'h80) ? 2'b00 : 2'b10;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_write(input logic [1:0] b);
        rsp_t e;
        e = '{32'h0, b, 8'd0, 1'b1};
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns #1 after the handshake edge.
    task automatic send_cmd(input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [7:0] cnt);
        int t;
        t = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_count = cnt;
        while (1) begin
            @(negedge mem_clk);
            if (cmd_ready) break;
            t++;
            if (t > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, want 1", t);
                break;
            end
        end
        @(posedge mem_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && t < 3000) begin
            @(posedge mem_clk);
            #1;
            t++;
        end
        if (t >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_done: got %0d results pending after %0d cycles, want 0", nm, exp_q.size(), t);
            exp_q.delete();
        end
    endtask

    initial begin
        int   lat, k;
        bit   stable, no_ar;
        rsp_t cap;

        vt[0] = '{1'b0, 32'h20, 32'h0,         8'd13,  2'b00, 0, 13};
        vt[1] = '{1'b0, 32'h60, 32'h0,         8'd2,   2'b00, 0, 2};
        vt[2] = '{1'b0, 32'h20, 32'h0,         8'd0,   2'b00, 0, 1};
        vt[3] = '{1'b1, 32'h20, 32'hA5A5_A5A5, 8'd7,   2'b00, 0, 1};
        vt[4] = '{1'b0, 32'h40, 32'h0,         8'd3,   2'b00, 1, 3};
        vt[5] = '{1'b1, 32'h80, 32'h1234_5678, 8'd0,   2'b10, 1, 1};
        vt[6] = '{1'b0, 32'h60, 32'h0,         8'd4,   2'b00, 1, 4};
        vt[7] = '{1'b0, 32'h80, 32'h0,         8'd255, 2'b00, 0, 255};

        fork
            rsp_drive();
            rsp_monitor();
        join_none

        // reset state
        repeat (3) @(posedge mem_clk);
        #1;
        chk("reset_outputs", {cmd_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready, timeout_sticky}, 8'h00);
        mem_aresetn = 1'b1;
        @(posedge mem_clk);
        #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // table-driven commands
        for (int v = 0; v < 8; v++) begin
            rsp_mode = vt[v].rmode;
            if (vt[v].wr) begin
                b_cfg = vt[v].bresp;
                push_write(vt[v].bresp);
            end else begin
                push_read(vt[v].addr, vt[v].exp_n);
            end
            send_cmd(vt[v].wr, vt[v].addr, vt[v].wdata, vt[v].cnt);
            wait_done($sformatf("vec%0d", v));
            if (vt[v].wr)
                chk($sformatf("vec%0d_wbus", v), {s_awaddr, s_wdata, s_wstrb}, {vt[v].addr, vt[v].wdata, 4'hF});
        end
        rsp_mode = 0;
        @(posedge mem_clk);
        #1;

        // minimum latency: rsp_valid in the 4th cycle counting the handshake cycle
        push_read(32'h20, 1);
        send_cmd(1'b0, 32'h20, 32'h0, 8'd1);
        lat = 0;
        while (lat < 50) begin
            @(negedge mem_clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("read_latency", lat, 3);
        wait_done("rd_lat");
        b_cfg = 2'b00;
        push_write(2'b00);
        send_cmd(1'b1, 32'h80, 32'h0BAD_F00D, 8'd0);
        lat = 0;
        while (lat < 50) begin
            @(negedge mem_clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("write_latency", lat, 3);
        wait_done("wr_lat");

        // awready three cycles ahead of wready
        w_rdy = 1'b0;
        b_cfg = 2'b10;
        push_write(2'b10);
        send_cmd(1'b1, 32'h20, 32'hA5A5_A5A5, 8'd0);
        @(negedge mem_clk);
        chk("aww_start", {awvalid, wvalid}, 2'b11);
        @(posedge mem_clk); #1;
        @(negedge mem_clk);
        chk("aw_dropped_1", {awvalid, wvalid}, 2'b01);
        @(posedge mem_clk); #1;
        @(negedge mem_clk);
        chk("aw_dropped_2", {awvalid, wvalid}, 2'b01);
        @(posedge mem_clk); #1;
        w_rdy = 1'b1;
        @(negedge mem_clk);
        chk("w_still_held", {awvalid, wvalid, bready}, 3'b010);
        wait_done("split_aw");
        chk("split_aw_wbus", {s_awaddr, s_wdata, s_wstrb}, {32'h20, 32'hA5A5_A5A5, 4'hF});
        b_cfg = 2'b00;

        // slave hangs on a count=3 read: timeout result is last, then drain
        r_hang = 1'b1;
        exp_q.push_back('{32'h0, 2'b11, 8'd0, 1'b1});
        send_cmd(1'b0, 32'h20, 32'h0, 8'd3);
        @(posedge mem_clk); #1;               // AR handshake edge
        chk("sticky_before_timeout", timeout_sticky, 0);
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(posedge mem_clk); #1;
            k++;
        end
        chk("timeout_latency", k, 16);
        chk("timeout_sticky_set", timeout_sticky, 1);
        while (k < 39) begin
            @(posedge mem_clk); #1;
            k++;
            if (k == 30) chk("drain_hold", {cmd_ready, rready, arvalid}, 3'b010);
        end
        r_force = 1'b1;
        @(posedge mem_clk); #1;
        r_force = 1'b0;
        chk("late_rvalid_seen", {s_rvalid, rready, cmd_ready}, 3'b110);
        @(posedge mem_clk); #1;
        chk("cmd_ready_after_drain", {cmd_ready, rready, timeout_sticky}, 3'b101);
        r_hang = 1'b0;
        wait_done("timeout");

        // result backpressure during a count=3 burst
        rsp_mode = 2;
        @(posedge mem_clk); #1;
        push_read(32'h20, 3);
        send_cmd(1'b0, 32'h20, 32'h0, 8'd3);
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge mem_clk);
            k++;
        end
        chk("bp_rsp_valid", rsp_valid, 1);
        cap = '{rsp_data, rsp_resp, rsp_index, rsp_last};
        stable = 1'b1;
        no_ar  = 1'b1;
        repeat (10) begin
            @(negedge mem_clk);
            if (!rsp_valid || cap !== rsp_t'({rsp_data, rsp_resp, rsp_index, rsp_last})) stable = 1'b0;
            if (arvalid) no_ar = 1'b0;
        end
        chk("bp_fields_stable", stable, 1);
        chk("bp_no_arvalid", no_ar, 1);
        rsp_mode = 0;
        wait_done("backpressure");

        // reset while waiting in R
        r_hang = 1'b1;
        send_cmd(1'b0, 32'h20, 32'h0, 8'd2);
        @(posedge mem_clk); #1;
        chk("in_R", {rready, arvalid}, 2'b10);
        mem_aresetn = 1'b0;
        @(posedge mem_clk); #1;
        chk("reset_in_R", {cmd_ready, rsp_valid, arvalid, rready, awvalid, wvalid, bready, timeout_sticky}, 8'h00);
        @(posedge mem_clk); #1;
        mem_aresetn = 1'b1;
        r_hang = 1'b0;
        chk("cmd_ready_in_reset", cmd_ready, 0);
        @(posedge mem_clk); #1;
        chk("cmd_ready_after_release", cmd_ready, 1);
        push_read(32'h20, 1);
        send_cmd(1'b0, 32'h20, 32'h0, 8'd1);
        wait_done("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
